// File: rtl/axis_skew_feeder.sv
// AXI-Stream to systolic skew-buffer feeder: forwards beats, appends Size-1 zero
// flush beats after each tlast, and tracks per-column validity through the skew.
module axis_skew_feeder #(
  parameter int Width    = 8,
  parameter int Size     = 4,
  parameter int MaxBeats = 1024,
  parameter int CW       = $clog2(MaxBeats + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [Size*Width-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  array_ready_i,
  output logic [Size*Width-1:0] x_o,
  output logic                  en_o,
  output logic [Size-1:0]       col_vld_o,
  output logic [Size-1:0]       col_last_o,
  output logic                  done_o,
  output logic [CW-1:0]         beats_o,
  output logic                  len_err_o
);

  localparam int FCW = (Size > 2) ? $clog2(Size - 1) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e            state_r, state_nx_s;
  logic [FCW-1:0]    fc_r, fc_nx_s;
  logic              fire_s, en_s, tready_s, done_set_s, over_s;
  logic [Size-1:1]   v_r, l_r;
  logic [CW-1:0]     bc_r, bc_nx_s, stage_r, beats_r;
  logic [CW:0]       bc_inc_s;
  logic              done_r, err_r;

  // Next-state, flush counting and handshake decode.
  always_comb begin
    state_nx_s = state_r;
    fc_nx_s    = fc_r;
    tready_s   = 1'b0;
    fire_s     = 1'b0;
    en_s       = 1'b0;
    case (state_r)
      ST_RUN: begin
        tready_s = array_ready_i;
        fire_s   = s_axis_tvalid & array_ready_i;
        en_s     = fire_s;
        if (fire_s && s_axis_tlast) begin
          state_nx_s = ST_FLUSH;
          fc_nx_s    = '0;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        en_s = array_ready_i;
        if (en_s) begin
          if (fc_r == FCW'(Size - 2)) begin
            state_nx_s = ST_RUN;
            fc_nx_s    = '0;
          end else begin
            fc_nx_s = fc_r + FCW'(1);
          end
        end else begin
          fc_nx_s = fc_r;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
        fc_nx_s    = '0;
      end
    endcase
  end

  // Beat count with saturation at MaxBeats.
  always_comb begin
    bc_inc_s = {1'b0, bc_r} + {{CW{1'b0}}, 1'b1};
    over_s   = (bc_inc_s > (CW+1)'(MaxBeats));
    if (over_s) begin
      bc_nx_s = CW'(MaxBeats);
    end else begin
      bc_nx_s = bc_inc_s[CW-1:0];
    end
  end

  assign done_set_s = l_r[Size-1] & en_s;

  // State, validity skew pipeline, counters and status registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_RUN;
      fc_r    <= '0;
      v_r     <= '0;
      l_r     <= '0;
      bc_r    <= '0;
      stage_r <= '0;
      beats_r <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      fc_r    <= fc_nx_s;
      if (fire_s) begin
        if (s_axis_tlast) begin
          stage_r <= bc_nx_s;
          bc_r    <= '0;
        end else begin
          bc_r <= bc_nx_s;
        end
        if (over_s) begin
          err_r <= 1'b1;
        end
      end
      // Pipeline advances only with the skew buffer so columns stay aligned.
      if (en_s) begin
        v_r[1] <= fire_s;
        l_r[1] <= fire_s & s_axis_tlast;
        for (int r = 2; r < Size; r++) begin
          v_r[r] <= v_r[r-1];
          l_r[r] <= l_r[r-1];
        end
      end
      done_r <= done_set_s;
      if (done_set_s) begin
        beats_r <= stage_r;
      end
    end
  end

  assign s_axis_tready = tready_s;
  assign en_o          = en_s;
  assign x_o           = fire_s ? s_axis_tdata : '0;
  assign col_vld_o     = {v_r, fire_s};
  assign col_last_o    = {l_r, fire_s & s_axis_tlast};
  assign done_o        = done_r;
  assign beats_o       = beats_r;
  assign len_err_o     = err_r;

endmodule
